// File: rtl/netlist_stream_evaluator.sv
// rtl/netlist_stream_evaluator.sv - streaming gate-level netlist evaluator
// Consumes gate/OUT records against a one-bit value file and captures primary outputs.
module netlist_stream_evaluator #(
  parameter int ID_W   = 7,
  parameter int NUM_PI = 14,
  parameter int NUM_PO = 8,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_PI-1:0] pi_vec,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [3:0]        rec_op,
  input  logic [ID_W-1:0]   rec_dst,
  input  logic [ID_W-1:0]   rec_a,
  input  logic [ID_W-1:0]   rec_b,
  input  logic              rec_last,
  output logic              busy,
  output logic              done,
  output logic [NUM_PO-1:0] po_vec,
  output logic              po_valid,
  output logic              err,
  output logic [CNT_W-1:0]  gate_cnt
);
  localparam int NETS = 2 ** ID_W;
  localparam int PO_W = $clog2(NUM_PO);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [NETS-1:0] nets, written;
  logic            s1_valid;
  logic [3:0]      s1_op;
  logic [ID_W-1:0] s1_dst, s1_a, s1_b;
  logic            accept, start_ok;
  logic            va, vb, wa, wb, uses_b, is_gate, is_out, fault, res;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign accept   = rec_valid && rec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rec_ready  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        rec_ready = 1'b1;
        busy      = 1'b1;
        if (rec_valid && rec_last) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE:  if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // The record in S1 reads the value file directly, so the write made by the
  // previous record on the preceding edge is already visible: no stall needed.
  always_comb begin
    va      = nets[s1_a];
    vb      = nets[s1_b];
    wa      = written[s1_a];
    wb      = written[s1_b];
    is_gate = (s1_op < 4'd8);
    is_out  = (s1_op == 4'd8);
    uses_b  = (s1_op >= 4'd2) && (s1_op <= 4'd7);
    fault   = !(is_gate || is_out) || !wa || (uses_b && !wb) ||
              (is_gate && (s1_dst < ID_W'(NUM_PI)));
    case (s1_op[2:0])
      3'd0: res = va;
      3'd1: res = ~va;
      3'd2: res = va & vb;
      3'd3: res = ~(va & vb);
      3'd4: res = va | vb;
      3'd5: res = ~(va | vb);
      3'd6: res = va ^ vb;
      3'd7: res = ~(va ^ vb);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nets     <= '0;
      written  <= '0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_dst   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      done     <= 1'b0;
      po_vec   <= '0;
      po_valid <= 1'b0;
      err      <= 1'b0;
      gate_cnt <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= rec_op;
        s1_dst <= rec_dst;
        s1_a   <= rec_a;
        s1_b   <= rec_b;
      end
      done <= (state == DRAIN);
      if (state == DRAIN) po_valid <= 1'b1;
      if (start_ok) begin
        nets     <= {{(NETS-NUM_PI){1'b0}}, pi_vec};
        written  <= {{(NETS-NUM_PI){1'b0}}, {NUM_PI{1'b1}}};
        po_vec   <= '0;
        err      <= 1'b0;
        gate_cnt <= '0;
        po_valid <= 1'b0;
      end else if (s1_valid) begin
        if (fault) begin
          err <= 1'b1;
        end else if (is_out) begin
          po_vec[s1_dst[PO_W-1:0]] <= va;
        end else begin
          nets[s1_dst]    <= res;
          written[s1_dst] <= 1'b1;
          if (gate_cnt != '1) gate_cnt <= gate_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_netlist_stream_evaluator.sv
// tb/tb_netlist_stream_evaluator.sv - self-checking bench for netlist_stream_evaluator
// Directed and random netlists compared against a sequential interpreter model.
module tb_netlist_stream_evaluator;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [13:0] pi_vec;
  logic        rec_valid, rec_ready, rec_last;
  logic [3:0]  rec_op;
  logic [6:0]  rec_dst, rec_a, rec_b;
  logic        busy, done, po_valid, err;
  logic [7:0]  po_vec;
  logic [9:0]  gate_cnt;

  netlist_stream_evaluator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pi_vec(pi_vec),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_op(rec_op),
    .rec_dst(rec_dst), .rec_a(rec_a), .rec_b(rec_b), .rec_last(rec_last),
    .busy(busy), .done(done), .po_vec(po_vec), .po_valid(po_valid),
    .err(err), .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [6:0] dst;
    logic [6:0] a;
    logic [6:0] b;
  } rec_t;

  rec_t recs[$];
  int   total = 0, passes = 0, fails = 0;
  logic [7:0] m_po;
  bit         m_err;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int op, input int dst, input int a, input int b);
    rec_t r;
    r.op = 4'(op); r.dst = 7'(dst); r.a = 7'(a); r.b = 7'(b);
    recs.push_back(r);
  endtask

  // Interprets the record list one record at a time, as the netlist semantics define it.
  task automatic model_run(input logic [13:0] pi);
    bit v[128];
    bit w[128];
    bit x, y, r;
    m_po = '0; m_err = 0; m_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      v[i] = (i < 14) ? pi[i] : 1'b0;
      w[i] = (i < 14);
    end
    foreach (recs[i]) begin
      if (recs[i].op > 8) m_err = 1;
      else if (!w[recs[i].a] || (recs[i].op inside {[2:7]} && !w[recs[i].b])) m_err = 1;
      else if (recs[i].op != 8 && recs[i].dst < 14) m_err = 1;
      else if (recs[i].op == 8) m_po[recs[i].dst % 8] = v[recs[i].a];
      else begin
        x = v[recs[i].a]; y = v[recs[i].b];
        case (recs[i].op)
          0: r = x;
          1: r = !x;
          2: r = x && y;
          3: r = !(x && y);
          4: r = x || y;
          5: r = !(x || y);
          6: r = x != y;
          default: r = x == y;
        endcase
        v[recs[i].dst] = r;
        w[recs[i].dst] = 1;
        if (m_cnt < 1023) m_cnt++;
      end
    end
  endtask

  task automatic gen_random(input int n);
    int drv[$];
    int k;
    recs.delete();
    for (int i = 0; i < 14; i++) drv.push_back(i);
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(99);
      if (k < 80) begin
        int d = $urandom_range(127, 14);
        add($urandom_range(7), d, drv[$urandom_range(drv.size()-1)], drv[$urandom_range(drv.size()-1)]);
        drv.push_back(d);
      end else if (k < 92) begin
        add(8, $urandom_range(7), drv[$urandom_range(drv.size()-1)], 0);
      end else begin
        add($urandom_range(15), $urandom_range(127), $urandom_range(127), $urandom_range(127));
      end
    end
    add(8, $urandom_range(7), drv[$urandom_range(drv.size()-1)], 0);
  endtask

  task automatic do_start(input logic [13:0] pi);
    pi_vec = pi;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic feed(input int gap_pct, input bit poke_start, input bit chk_ready);
    foreach (recs[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        rec_valid = 1'b0;
        rec_op    = 4'($urandom);
        rec_dst   = 7'($urandom);
        rec_a     = 7'($urandom);
        rec_last  = 1'($urandom);
        start     = poke_start;
        pi_vec    = 14'($urandom);
        @(negedge clk);
      end
      start     = 1'b0;
      rec_valid = 1'b1;
      rec_op    = recs[i].op;
      rec_dst   = recs[i].dst;
      rec_a     = recs[i].a;
      rec_b     = recs[i].b;
      rec_last  = (i == recs.size() - 1);
      if (chk_ready) chk("ready_in_run", rec_ready, 1);
      @(negedge clk);
    end
    rec_valid = 1'b0;
    rec_last  = 1'b0;
  endtask

  task automatic finish_pass(input string tag);
    int lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_latency"}, lat, 1);
    chk({tag, "_po_vec"}, po_vec, m_po);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_gate_cnt"}, gate_cnt, m_cnt);
    chk({tag, "_po_valid"}, po_valid, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_po_valid_hold"}, po_valid, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rec_ready"}, rec_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_po_valid"}, po_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_po_vec"}, po_vec, 0);
    chk({tag, "_gate_cnt"}, gate_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  po_ref;
    logic [13:0] pi;
    rst_n = 1'b0; start = 1'b0; pi_vec = '0; rec_valid = 1'b0;
    rec_op = '0; rec_dst = '0; rec_a = '0; rec_b = '0; rec_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    recs.delete();
    add(3, 20, 0, 1); add(8, 0, 20, 0);
    model_run(14'h0003);
    do_start(14'h0003);
    feed(0, 0, 0);
    finish_pass("nand");
    chk("nand_po0", po_vec[0], 0);
    chk("nand_cnt", gate_cnt, 1);
    chk("nand_err", err, 0);

    recs.delete();
    add(1, 30, 2, 0); add(1, 31, 30, 0); add(7, 32, 31, 2); add(8, 3, 32, 0);
    model_run(14'h0004);
    do_start(14'h0004);
    feed(0, 0, 1);
    finish_pass("fwd");
    chk("fwd_po3", po_vec[3], 1);

    recs.delete();
    add(3, 5, 0, 1); add(8, 1, 5, 0); add(1, 40, 99, 0); add(8, 2, 40, 0);
    add(12, 50, 0, 1); add(0, 21, 0, 0); add(8, 4, 21, 0);
    model_run(14'h0027);
    do_start(14'h0027);
    feed(0, 0, 0);
    finish_pass("errs");
    chk("errs_err", err, 1);
    chk("errs_pi5_kept", po_vec[1], 1);
    chk("errs_po2_uncaptured", po_vec[2], 0);

    recs.delete();
    add(8, 6, 9, 0);
    model_run(14'h0200);
    do_start(14'h0200);
    chk("restart_po_valid", po_valid, 0);
    chk("restart_err", err, 0);
    chk("restart_gate_cnt", gate_cnt, 0);
    chk("restart_busy", busy, 1);
    feed(0, 0, 0);
    finish_pass("restart");

    for (int it = 0; it < 3; it++) begin
      pi = 14'($urandom);
      gen_random(40);
      model_run(pi);
      do_start(pi);
      feed(0, 0, 0);
      finish_pass("rand_nogap");
      po_ref = po_vec;
      do_start(pi);
      feed(40, 1, 0);
      finish_pass("rand_gap");
      chk("rand_gap_vs_nogap", po_vec, po_ref);
    end

    do_start(14'h3fff);
    rec_valid = 1'b1; rec_op = 4'd2; rec_dst = 7'd60; rec_a = 7'd0; rec_b = 7'd1; rec_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    rec_valid = 1'b0;
    @(negedge clk);
    recs.delete();
    add(3, 20, 0, 1); add(8, 0, 20, 0);
    model_run(14'h0003);
    do_start(14'h0003);
    feed(0, 0, 0);
    finish_pass("post_reset");

    recs.delete();
    for (int i = 0; i < 1029; i++) add(0, 20, 0, 0);
    pi = 14'($urandom) | 14'h0001;
    model_run(pi);
    do_start(pi);
    feed(0, 0, 0);
    finish_pass("sat");
    chk("sat_cnt", gate_cnt, 1023);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/netlist_stream_evaluator.md
Name: netlist_stream_evaluator

Overview:
- Sequential evaluator that consumes a serialized gate-level netlist and computes primary-output values for one primary-input vector.
- Record stream: one gate or output record per transfer, cells NOT/NAND/NOR/XNOR plus AND/OR/XOR/BUF; nets addressed by ID.
- Reader/consumer for netlists produced by the conversion and optimization flow. Used on-chip for equivalence spot-checks of converted designs against golden vectors.

Parameters:
ID_W, 7, net ID width; value file holds 2**ID_W one-bit nets
NUM_PI, 14, primary inputs; preloaded into net IDs 0..NUM_PI-1
NUM_PO, 8, primary outputs, indexed by rec_dst[2:0] for OUT records
CNT_W, 10, width of evaluated-gate counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin evaluation pass; sampled in IDLE or DONE only
pi_vec  in  NUM_PI  input vector; bit i loads net i on accepted start
rec_valid  in  1  record valid
rec_ready  out  1  high only in RUN
rec_op  in  4  0 BUF, 1 NOT, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR, 8 OUT, 9-15 illegal
rec_dst  in  ID_W  destination net; OUT uses [2:0] as PO index
rec_a  in  ID_W  operand A net
rec_b  in  ID_W  operand B net; ignored for BUF/NOT/OUT
rec_last  in  1  final record of pass
busy  out  1  state is RUN or DRAIN
done  out  1  one-cycle pulse at end of pass
po_vec  out  NUM_PO  captured outputs
po_valid  out  1  high in DONE until next accepted start
err  out  1  sticky error for the pass
gate_cnt  out  CNT_W  gate records evaluated this pass, saturating

Behaviour:
- Reset:
  - state=IDLE; all outputs 0 (rec_ready, busy, done, po_valid, err, po_vec, gate_cnt).
  - Value file and written-bitmap are cleared.
  - Reset mid-pass aborts immediately; no partial done.
- FSM: IDLE -> RUN on start. RUN -> DRAIN when a record with rec_last is accepted. DRAIN -> DONE after 1 cycle. DONE -> RUN on start. start is ignored in RUN and DRAIN.
- Accepted start, same edge:
  - load pi_vec into nets 0..NUM_PI-1;
  - written-bitmap becomes exactly those bits;
  - clear po_vec, err, gate_cnt, po_valid.
- Transfer: rec_valid & rec_ready. Gaps are allowed; no throughput penalty.
- Pipeline, 2 stages:
  - S1 registers the accepted record.
  - Next edge S2 evaluates it and writes the result into net rec_dst, setting its bitmap bit.
  - Sustained rate is 1 record/cycle.
- Operand forwarding: if the record in S1 reads the net being written by S2 that same cycle, the S2 result is used. Back-to-back dependent records must evaluate correctly with no stall.
- OUT record: po_vec[rec_dst[2:0]] <= value of net rec_a. No net write; gate_cnt unchanged.
- Gate records (ops 0-7) increment gate_cnt; saturates at all-ones.
- Errors (err set, sticky until next start; the faulting record performs no write and no PO capture, the pass continues):
  - illegal op;
  - gate dst < NUM_PI (PI overwrite);
  - an operand read from a net with bitmap bit 0 (undriven). Forwarded values count as written.
- Rewriting an already-written non-PI net is legal; the last write wins.
- done:
  - Asserts for exactly one cycle, in the cycle after the final record's S2 write edge; state=DONE in that cycle.
  - po_valid rises the same cycle and holds.
- A start arriving in the same cycle done is high is accepted, because state is already DONE.

Test Plan:
- Basic NAND: start with pi bits 0=1, 1=1; records NAND dst=20 a=0 b=1, then OUT dst=0 a=20 last -> done after final write; po_vec[0]=0; gate_cnt=1; err=0.
- Forwarding: pi bit 2=1; records NOT 30<-2, NOT 31<-30, XNOR 32<-31,2, OUT po3<-32 last, on consecutive cycles, no gaps -> po_vec[3]=1; no stall; rec_ready high throughout.
- Errors:
  - NAND dst=5 (a PI) -> err=1, net 5 keeps its PI value;
  - NOT 40<-99 (undriven) -> err=1, net 40 not written;
  - op=12 -> err=1;
  - the pass still reaches done.
- Backpressure, gaps, restart:
  - random rec_valid gaps give the same po_vec as the gapless run;
  - start during RUN is ignored;
  - start in DONE clears po_valid, err and gate_cnt.
- Reset: deassert rst_n mid-RUN -> all outputs 0 immediately; a following start with a clean pass gives the correct result.
- Saturation: (2**CNT_W)+5 BUF records -> gate_cnt=1023 with the default CNT_W; no wrap.
